// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and address helper for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_LIMIT = 8188;

  // Instruction word decode substitutes on bubbles (addi x0, x0, 0).
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] limit_addr(input logic [31:0] pc, input logic [31:0] limit);
    return (pc > limit) ? 32'h0 : pc;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO used for both the in-flight tag queue and the decoded instruction queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when a pop frees the slot in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !clear_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC-addressed memory requests, queues {pc, inst} pairs for decode and
// discards stale responses after a redirect. Define FETCH_BYPASS_EN for 0-cycle response bypass.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [31:0] iv_Pc,
  output logic        o_Pc_Enb,
  input  logic        i_Flush,
  output logic        o_Req_Valid,
  output logic [31:0] ov_Req_Addr,
  input  logic        i_Req_Ready,
  input  logic        i_Rsp_Valid,
  input  logic [31:0] iv_Rsp_Data,
  output logic        o_Inst_Valid,
  output logic [31:0] ov_Inst,
  output logic [31:0] ov_Inst_Pc,
  input  logic        i_Inst_Ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Repeated redirects can leave more stale responses outstanding than DEPTH.
  localparam int unsigned DW = CW + 4;

  localparam logic [0:0] StIdle = IDLE;
  localparam logic [0:0] StRun  = RUN;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] drop_q, drop_d;

  logic [CW-1:0] inflight;
  logic [CW-1:0] occupancy;
  logic [CW:0]   pending;
  logic          accept;
  logic          rsp_kept;
  logic          rsp_push;
  logic          bypass;
  logic          inst_pop;
  logic [31:0]   tag_pc;
  logic [63:0]   inst_data;
  logic          tag_full, tag_empty, inst_full, inst_empty;
  logic          unused_flags;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Issue side
  assign pending     = {1'b0, inflight} + {1'b0, occupancy};
  assign o_Req_Valid = (state_q == StRun) && !i_Flush && (pending < (CW + 1)'(DEPTH));
  assign ov_Req_Addr = limit_addr(iv_Pc, 32'(ADDR_LIMIT));
  assign accept      = o_Req_Valid && i_Req_Ready;
  assign o_Pc_Enb    = accept;

  // Response side: a kept response is one that arrives with nothing left to drop.
  assign rsp_kept = i_Rsp_Valid && (drop_q == '0);
  assign rsp_push = rsp_kept && !i_Flush;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_push && inst_empty && i_Inst_Ready;
`else
  assign bypass = 1'b0;
`endif

  assign inst_pop     = !inst_empty && i_Inst_Ready && !i_Flush;
  assign o_Inst_Valid = !inst_empty || bypass;
  assign {ov_Inst_Pc, ov_Inst} = bypass ? {tag_pc, iv_Rsp_Data} : inst_data;

  always_comb begin
    drop_d = drop_q;
    if (i_Flush) begin
      // Every response arriving this cycle is consumed, whether it was stale or would be kept.
      drop_d = drop_q + DW'(inflight) - DW'(i_Rsp_Valid);
    end else if (i_Rsp_Valid && (drop_q != '0)) begin
      drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= StIdle;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Tag FIFO occupancy is the count of live in-flight requests.
  fetch_queue #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .push_i  (accept),
    .data_i  (ov_Req_Addr),
    .pop_i   (rsp_push),
    .clear_i (i_Flush),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (inflight)
  );

  fetch_queue #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .push_i  (rsp_push && !bypass),
    .data_i  ({tag_pc, iv_Rsp_Data}),
    .pop_i   (inst_pop),
    .clear_i (i_Flush),
    .data_o  (inst_data),
    .full_o  (inst_full),
    .empty_o (inst_empty),
    .count_o (occupancy)
  );

  assign unused_flags = ^{tag_full, tag_empty, inst_full};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, inst} pairs are queued on request acceptance
// and checked by an independent monitor whenever decode consumes an instruction.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iv_Pc;
  logic        o_Pc_Enb;
  logic        i_Flush;
  logic        o_Req_Valid;
  logic [31:0] ov_Req_Addr;
  logic        i_Req_Ready;
  logic        i_Rsp_Valid;
  logic [31:0] iv_Rsp_Data;
  logic        o_Inst_Valid;
  logic [31:0] ov_Inst;
  logic [31:0] ov_Inst_Pc;
  logic        i_Inst_Ready;

  fetch_unit #(
    .DEPTH      (DEPTH),
    .ADDR_LIMIT (8188)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .iv_Pc        (iv_Pc),
    .o_Pc_Enb     (o_Pc_Enb),
    .i_Flush      (i_Flush),
    .o_Req_Valid  (o_Req_Valid),
    .ov_Req_Addr  (ov_Req_Addr),
    .i_Req_Ready  (i_Req_Ready),
    .i_Rsp_Valid  (i_Rsp_Valid),
    .iv_Rsp_Data  (iv_Rsp_Data),
    .o_Inst_Valid (o_Inst_Valid),
    .ov_Inst      (ov_Inst),
    .ov_Inst_Pc   (ov_Inst_Pc),
    .i_Inst_Ready (i_Inst_Ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic [31:0] data;} item_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] due;} mreq_t;

  item_t       exp_q[$];
  mreq_t       memq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        mem_hold = 1'b0;
  logic [31:0] flush_tgt = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] fpc(input logic [31:0] p);
    return (p > 32'd8188) ? 32'h0 : p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    i_Req_Ready = 1'b0;
    mem_hold    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && memq.size() == 0) break;
      step();
    end
    step();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // PC register and request acceptance model
  initial forever begin
    logic acc, flush_s;
    @(negedge clk);
    acc     = o_Req_Valid && i_Req_Ready;
    flush_s = i_Flush;
    check("pc_enb", {31'h0, o_Pc_Enb}, {31'h0, acc});
    if (acc) begin
      n_acc++;
      exp_q.push_back({fpc(iv_Pc), mem_word(fpc(iv_Pc))});
      memq.push_back({ov_Req_Addr, 32'(cyc + lat)});
    end
    @(posedge clk);
    #1;
    if (flush_s) iv_Pc = flush_tgt;
    else if (acc) iv_Pc = iv_Pc + 32'd4;
  end

  // In-order memory with programmable latency
  initial begin
    i_Rsp_Valid = 1'b0;
    iv_Rsp_Data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      i_Rsp_Valid = 1'b0;
      if (!mem_hold && memq.size() > 0 && memq[0].due <= 32'(cyc)) begin
        i_Rsp_Valid = 1'b1;
        iv_Rsp_Data = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end
    end
  end

  // Decode-side monitor
  initial forever begin
    @(negedge clk);
    if (!rst && o_Inst_Valid && i_Inst_Ready && !i_Flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_inst: got pc %h, expected no instruction", ov_Inst_Pc);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        check("inst_pc", ov_Inst_Pc, e.pc);
        check("inst_data", ov_Inst, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    rst          = 1'b1;
    i_Flush      = 1'b0;
    i_Req_Ready  = 1'b0;
    i_Inst_Ready = 1'b0;
    iv_Pc        = 32'd8192;
    #3;
    check("rst_req_valid", {31'h0, o_Req_Valid}, 32'd0);
    check("rst_pc_enb", {31'h0, o_Pc_Enb}, 32'd0);
    check("rst_inst_valid", {31'h0, o_Inst_Valid}, 32'd0);
    check("rst_inst", ov_Inst, 32'd0);
    check("rst_inst_pc", ov_Inst_Pc, 32'd0);
    check("rst_addr_forced", ov_Req_Addr, 32'd0);
    iv_Pc = 32'd8188;
    #1;
    check("addr_at_limit", ov_Req_Addr, 32'd8188);
    iv_Pc        = 32'd0;
    i_Req_Ready  = 1'b1;
    i_Inst_Ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #2;
    check("idle_after_reset", {31'h0, o_Req_Valid}, 32'd0);
    step();
    #2;
    check("first_req", {31'h0, o_Req_Valid}, 32'd1);

    // Streaming with decode always ready, PC 0, 4, 8, ...
    repeat (10) step();
    drain("t1_drain");

    // Decode stall: only DEPTH requests may be outstanding or buffered
    i_Inst_Ready = 1'b0;
    i_Req_Ready  = 1'b1;
    a0 = n_acc;
    repeat (6) step();
    #2;
    check("stall_accepts", 32'(n_acc - a0), 32'd2);
    check("stall_no_req", {31'h0, o_Req_Valid}, 32'd0);
    check("stall_valid", {31'h0, o_Inst_Valid}, 32'd1);
    check("stall_hold_pc", ov_Inst_Pc, exp_q[0].pc);
    check("stall_hold_inst", ov_Inst, exp_q[0].data);
    i_Inst_Ready = 1'b1;
    step();
    i_Inst_Ready = 1'b0;
    #2;
    check("req_after_pop", {31'h0, o_Req_Valid}, 32'd1);
    i_Inst_Ready = 1'b1;
    drain("t2_drain");

    // Flush with PC 8 and 12 in flight, redirect to 100
    iv_Pc       = 32'd8;
    mem_hold    = 1'b1;
    i_Req_Ready = 1'b1;
    a0 = n_acc;
    repeat (3) step();
    i_Req_Ready = 1'b0;
    check("t3_accepts", 32'(n_acc - a0), 32'd2);
    i_Flush   = 1'b1;
    flush_tgt = 32'd100;
    exp_q.delete();
    #2;
    check("flush_no_req", {31'h0, o_Req_Valid}, 32'd0);
    step();
    i_Flush  = 1'b0;
    mem_hold = 1'b0;
    #2;
    check("post_flush_valid", {31'h0, o_Inst_Valid}, 32'd0);
    i_Req_Ready = 1'b1;
    step();
    i_Req_Ready = 1'b0;
    drain("t3_drain");

    // Flush coinciding with a keepable response and a decode pop
    i_Inst_Ready = 1'b0;
    mem_hold     = 1'b1;
    iv_Pc        = 32'd40;
    i_Req_Ready  = 1'b1;
    a0 = n_acc;
    repeat (2) step();
    i_Req_Ready = 1'b0;
    mem_hold    = 1'b0;
    check("t4_accepts", 32'(n_acc - a0), 32'd2);
    step();
    i_Flush      = 1'b1;
    i_Inst_Ready = 1'b1;
    flush_tgt    = 32'd200;
    exp_q.delete();
    #2;
    check("pre_flush_valid", {31'h0, o_Inst_Valid}, 32'd1);
    step();
    i_Flush = 1'b0;
    #2;
    check("flush_pop_cleared", {31'h0, o_Inst_Valid}, 32'd0);
    i_Req_Ready = 1'b1;
    step();
    i_Req_Ready = 1'b0;
    drain("t4_drain");

    // Address forcing above the limit, then a run across it
    iv_Pc = 32'd8196;
    #2;
    check("addr_8196", ov_Req_Addr, 32'd0);
    iv_Pc = 32'd8192;
    #1;
    check("addr_8192", ov_Req_Addr, 32'd0);
    iv_Pc        = 32'd8184;
    i_Inst_Ready = 1'b1;
    i_Req_Ready  = 1'b1;
    repeat (5) step();
    drain("t5_drain");

`ifdef FETCH_BYPASS_EN
    // Bypass: empty queue, kept response, decode ready
    iv_Pc       = 32'd300;
    mem_hold    = 1'b1;
    i_Req_Ready = 1'b1;
    step();
    i_Req_Ready = 1'b0;
    mem_hold    = 1'b0;
    #2;
    check("bypass_valid", {31'h0, o_Inst_Valid}, 32'd1);
    check("bypass_pc", ov_Inst_Pc, 32'd300);
    step();
    #2;
    check("bypass_no_queue", {31'h0, o_Inst_Valid}, 32'd0);
    drain("t6_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
